// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA result streamer.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_END,
    FETCH,
    LATCH,
    SEND,
    DONE
  } stream_state_t;

  // Counter width able to index n distinct values, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rsa_result_streamer_if.sv
// Bus bundle between the streamer, the core's data-memory read port and the byte consumer.
interface rsa_result_streamer_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 10
);

  // Control from the core.
  logic                  start;
  logic                  end_flag;
  // Data-memory read port: mem_rdata is valid one cycle after mem_addr.
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_rdata;
  // Byte stream. A chunk moves on a rising edge where byte_valid and byte_ready
  // are both 1; once byte_valid rises, byte_out and byte_valid hold steady until
  // that transfer happens, and byte_ready may toggle freely without side effects.
  logic [BYTE_W-1:0]     byte_out;
  logic                  byte_valid;
  logic                  byte_ready;
  // Status.
  logic                  com_flag;
  logic                  done;
  // Debug view of the controller state.
  rsa_pkg::stream_state_t state;

  modport master (
    input  start, end_flag, mem_rdata, byte_ready,
    output mem_addr, byte_out, byte_valid, com_flag, done, state
  );

  modport slave (
    output start, end_flag, mem_rdata, byte_ready,
    input  mem_addr, byte_out, byte_valid, com_flag, done, state
  );

endinterface

// File: rtl/rsa_result_streamer_chunk_sel.sv
// Picks chunk number idx out of a memory word, counting from either end.
module rsa_result_streamer_chunk_sel #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [CW-1:0]     idx,
  output logic [BYTE_W-1:0] chunk
);

  localparam int CHUNKS = DATA_W / BYTE_W;

  // Plain mux: chunk 0 is the top slice when MSB_FIRST, the bottom slice otherwise.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx == CW'(i)) begin
        if (MSB_FIRST) chunk = word[(CHUNKS-1-i)*BYTE_W +: BYTE_W];
        else           chunk = word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/rsa_result_streamer.sv
// Streams a window of data memory out as byte chunks once the core signals completion.
module rsa_result_streamer
  import rsa_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  rsa_result_streamer_if.master bus
);

  localparam int CHUNKS = DATA_W / BYTE_W;
  localparam int CW     = cnt_w(CHUNKS);
  localparam int WW     = cnt_w(NUM_WORDS + 1);
  localparam logic [CW-1:0]     LAST_CHUNK = CW'(CHUNKS - 1);
  localparam logic [WW-1:0]     LAST_WORD  = WW'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("DATA_W must be an integer multiple of BYTE_W");
  end
  if (BASE_ADDR + NUM_WORDS > 2**ADDR_W) begin : g_bad_window
    $error("result window runs past the end of the address space");
  end

  stream_state_t     state;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] word_reg;
  logic [WW-1:0]     word_cnt;
  logic [CW-1:0]     chunk_cnt;
  logic              byte_valid;
  logic              com_flag;
  logic              done;
  logic              xfer;

  assign xfer = byte_valid & bus.byte_ready;

  // Controller: arm, wait for the core, then fetch/latch/send each word in turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_addr   <= BASE;
      word_reg   <= '0;
      word_cnt   <= '0;
      chunk_cnt  <= '0;
      byte_valid <= 1'b0;
      com_flag   <= 1'b0;
      done       <= 1'b0;
    end else if (!bus.start && state != IDLE) begin
      // Abort: whatever was in flight is dropped.
      state      <= IDLE;
      mem_addr   <= BASE;
      word_cnt   <= '0;
      chunk_cnt  <= '0;
      byte_valid <= 1'b0;
      com_flag   <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= WAIT_END;
        end
        WAIT_END: begin
          if (bus.end_flag) begin
            state    <= FETCH;
            word_cnt <= '0;
            mem_addr <= BASE;
            com_flag <= 1'b1;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          word_reg   <= bus.mem_rdata;
          chunk_cnt  <= '0;
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (xfer) begin
            if (chunk_cnt != LAST_CHUNK) begin
              chunk_cnt <= chunk_cnt + CW'(1);
            end else if (word_cnt != LAST_WORD) begin
              byte_valid <= 1'b0;
              word_cnt   <= word_cnt + WW'(1);
              mem_addr   <= mem_addr + ADDR_W'(1);
              state      <= FETCH;
            end else begin
              byte_valid <= 1'b0;
              com_flag   <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          com_flag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rsa_result_streamer_chunk_sel #(
    .DATA_W   (DATA_W),
    .BYTE_W   (BYTE_W),
    .MSB_FIRST(MSB_FIRST),
    .CW       (CW)
  ) u_chunk_sel (
    .word (word_reg),
    .idx  (chunk_cnt),
    .chunk(bus.byte_out)
  );

  assign bus.mem_addr   = mem_addr;
  assign bus.byte_valid = byte_valid;
  assign bus.com_flag   = com_flag;
  assign bus.done       = done;
  assign bus.state      = state;

endmodule

// File: tb/tb_rsa_result_streamer.sv
// Directed bench for rsa_result_streamer: three instances cover MSB-first,
// LSB-first and a single-byte window.
module tb_rsa_result_streamer;
  import rsa_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mon_sel  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  rsa_result_streamer_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(10)) ia ();
  rsa_result_streamer_if #(.DATA_W(32), .BYTE_W(8), .ADDR_W(10)) ib ();
  rsa_result_streamer_if #(.DATA_W(8),  .BYTE_W(8), .ADDR_W(10)) ic ();

  rsa_result_streamer #(
    .DATA_W(32), .BYTE_W(8), .ADDR_W(10), .BASE_ADDR(0), .NUM_WORDS(2), .MSB_FIRST(1'b1)
  ) dut_a (.clk(clk), .reset(reset), .bus(ia));

  rsa_result_streamer #(
    .DATA_W(32), .BYTE_W(8), .ADDR_W(10), .BASE_ADDR(0), .NUM_WORDS(2), .MSB_FIRST(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .bus(ib));

  rsa_result_streamer #(
    .DATA_W(8), .BYTE_W(8), .ADDR_W(10), .BASE_ADDR(5), .NUM_WORDS(1), .MSB_FIRST(1'b1)
  ) dut_c (.clk(clk), .reset(reset), .bus(ic));

  // ---------------- memory models (registered read) ----------------
  function automatic logic [31:0] mem_word(input logic [9:0] a);
    case (a)
      10'd0:   return 32'hA1B2C3D4;
      10'd1:   return 32'h11223344;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    ia.mem_rdata <= mem_word(ia.mem_addr);
    ib.mem_rdata <= mem_word(ib.mem_addr);
    ic.mem_rdata <= (ic.mem_addr == 10'd5) ? 8'h5A : 8'hEE;
  end

  // ---------------- transfer monitor ----------------
  always @(negedge clk) begin
    case (mon_sel)
      0: if (ia.byte_valid && ia.byte_ready) got_q.push_back(ia.byte_out);
      1: if (ib.byte_valid && ib.byte_ready) got_q.push_back(ib.byte_out);
      default: if (ic.byte_valid && ic.byte_ready) got_q.push_back(ic.byte_out);
    endcase
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_done();
    case (mon_sel)
      0:       return ia.done;
      1:       return ib.done;
      default: return ic.done;
    endcase
  endfunction

  task automatic run_until_done(input string tag, output int n);
    n = 0;
    while (!sel_done() && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int count);
    int n = 0;
    while (got_q.size() < count && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF,
            {24'h0, exp_q[i]});
    end
  endtask

  task automatic load_msb();
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic addr_ok;
    ia.start = 0; ia.end_flag = 0; ia.byte_ready = 0;
    ib.start = 0; ib.end_flag = 0; ib.byte_ready = 0;
    ic.start = 0; ic.end_flag = 0; ic.byte_ready = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",   32'(ia.state), 32'(IDLE));
    check("rst_addr",    32'(ia.mem_addr), 32'd0);
    check("rst_byte",    32'(ia.byte_out), 32'd0);
    check("rst_valid",   32'(ia.byte_valid), 32'd0);
    check("rst_com",     32'(ia.com_flag), 32'd0);
    check("rst_done",    32'(ia.done), 32'd0);
    check("rst_addr_c",  32'(ic.mem_addr), 32'd5);
    reset = 1'b1;
    tick();

    // 1: MSB first, two words, ready high
    mon_sel = 0; got_q.delete();
    ia.byte_ready = 1; ia.start = 1;
    tick();
    check("t1_wait", 32'(ia.state), 32'(WAIT_END));
    tick();
    check("t1_hold_wait", 32'(ia.state), 32'(WAIT_END));
    check("t1_com_pre", 32'(ia.com_flag), 32'd0);
    ia.end_flag = 1;
    tick();
    check("t1_fetch", 32'(ia.state), 32'(FETCH));
    check("t1_com", 32'(ia.com_flag), 32'd1);
    run_until_done("t1", n);
    check("t1_latency", 32'(n), 32'd12);
    check("t1_done", 32'(ia.done), 32'd1);
    check("t1_com_end", 32'(ia.com_flag), 32'd0);
    check("t1_valid_end", 32'(ia.byte_valid), 32'd0);
    check("t1_last_addr", 32'(ia.mem_addr), 32'd1);
    load_msb();
    check_seq("t1_seq");
    tick();
    check("t1_done_hold", 32'(ia.state), 32'(DONE));
    ia.start = 0; ia.end_flag = 0;
    tick();
    check("t1_idle", 32'(ia.state), 32'(IDLE));
    check("t1_done_clr", 32'(ia.done), 32'd0);

    // 2: LSB first
    mon_sel = 1; got_q.delete();
    ib.byte_ready = 1; ib.start = 1; ib.end_flag = 1;
    run_until_done("t2", n);
    exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
    check_seq("t2_seq");
    ib.start = 0; ib.end_flag = 0;
    tick();

    // 3: consumer stalls for three cycles mid-word
    mon_sel = 0; got_q.delete();
    ia.byte_ready = 1; ia.end_flag = 1; ia.start = 1;
    wait_bytes("t3", 2);
    ia.byte_ready = 0;
    check("t3_stall_byte", 32'(ia.byte_out), 32'hC3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_byte", 32'(ia.byte_out), 32'hC3);
      check("t3_hold_valid", 32'(ia.byte_valid), 32'd1);
    end
    ia.byte_ready = 1;
    run_until_done("t3", n);
    load_msb();
    check_seq("t3_seq");
    ia.start = 0; ia.end_flag = 0;
    tick();

    // 4: abort after the third byte, then a full rerun
    got_q.delete();
    ia.byte_ready = 1; ia.end_flag = 1; ia.start = 1;
    wait_bytes("t4", 3);
    ia.start = 0; ia.byte_ready = 0;
    tick();
    check("t4_valid", 32'(ia.byte_valid), 32'd0);
    check("t4_com", 32'(ia.com_flag), 32'd0);
    check("t4_state", 32'(ia.state), 32'(IDLE));
    got_q.delete();
    ia.start = 1; ia.byte_ready = 1;
    run_until_done("t4", n);
    load_msb();
    check_seq("t4_seq");
    ia.start = 0; ia.end_flag = 0;
    tick();

    // 5: asynchronous reset between clock edges during SEND
    got_q.delete();
    ia.byte_ready = 1; ia.end_flag = 1; ia.start = 1;
    wait_bytes("t5", 1);
    check("t5_pre_byte", 32'(ia.byte_out), 32'hB2);
    #2 reset = 1'b0;
    #1;
    check("t5_state", 32'(ia.state), 32'(IDLE));
    check("t5_byte", 32'(ia.byte_out), 32'd0);
    check("t5_valid", 32'(ia.byte_valid), 32'd0);
    check("t5_com", 32'(ia.com_flag), 32'd0);
    check("t5_done", 32'(ia.done), 32'd0);
    check("t5_addr", 32'(ia.mem_addr), 32'd0);
    ia.start = 0; ia.end_flag = 0; ia.byte_ready = 0;
    tick();
    reset = 1'b1;
    tick();

    // 6: single 8-bit word at BASE_ADDR=5
    mon_sel = 2; got_q.delete();
    ic.byte_ready = 1; ic.end_flag = 1; ic.start = 1;
    addr_ok = 1'b1;
    n = 0;
    while (!ic.done && n < 200) begin
      tick();
      n++;
      if (ic.mem_addr != 10'd5) addr_ok = 1'b0;
    end
    check("t6_timeout", 32'(n < 200), 32'd1);
    check("t6_latency", 32'(n), 32'd5);
    check("t6_addr_stable", 32'(addr_ok), 32'd1);
    check("t6_done", 32'(ic.done), 32'd1);
    exp_q = '{8'h5A};
    check_seq("t6_seq");
    ic.start = 0; ic.end_flag = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
